// File: rtl/clock_enable_gen.sv
// clock_enable_gen
//   Qualifies the raw PLL lock, sequences a registered synchronous system
//   reset from it, and produces CHANNELS programmable clock-enable strobes
//   from the single PLL output clock.
//
// Ports
//   clk          PLL output clock, the only clock in this block
//   resetn       asynchronous active-low reset
//   pll_locked   raw PLL lock, asynchronous to clk
//   div_wr       divisor write strobe
//   div_sel      channel index of the write (out-of-range indices ignored)
//   div_data     new divisor value
//   ready        high while in RUN
//   sys_resetn   registered active-low reset for downstream logic
//   lock_dropped sticky flag: lock lost after RUN was first reached
//   en           per-channel single-cycle enable strobes
module clock_enable_gen #(
    parameter int CHANNELS    = 4,
    parameter int CNT_WIDTH   = 16,
    parameter int HOLD_CYCLES = 1024,
    parameter logic [CHANNELS*CNT_WIDTH-1:0] DIV_INIT = {CHANNELS{CNT_WIDTH'(1)}},
    localparam int SEL_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 pll_locked,
    input  logic                 div_wr,
    input  logic [SEL_W-1:0]     div_sel,
    input  logic [CNT_WIDTH-1:0] div_data,
    output logic                 ready,
    output logic                 sys_resetn,
    output logic                 lock_dropped,
    output logic [CHANNELS-1:0]  en
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0]    HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0]    HOLD_ZERO = {HOLD_W{1'b0}};
    localparam logic [CNT_WIDTH-1:0] ONE_C     = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] ZERO_C    = {CNT_WIDTH{1'b0}};
    localparam logic                 SINGLE_HOLD = (HOLD_CYCLES == 32'sd1);

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_HOLD      = 2'd1,
        ST_RUN       = 2'd2
    } state_t;

    state_t              state_r;
    logic [HOLD_W-1:0]   hold_cnt_r;
    logic                lock_meta_r;
    logic                lock_s_r;
    logic                ready_r;
    logic                sys_resetn_r;
    logic                lock_dropped_r;
    logic                go_run_s;

    logic [CNT_WIDTH-1:0] cnt_r     [CHANNELS];
    logic [CNT_WIDTH-1:0] act_r     [CHANNELS];
    logic [CNT_WIDTH-1:0] shd_r     [CHANNELS];
    logic [CNT_WIDTH-1:0] cnt_nxt_s [CHANNELS];
    logic [CNT_WIDTH-1:0] act_nxt_s [CHANNELS];
    logic [CNT_WIDTH-1:0] shd_nxt_s [CHANNELS];
    logic [CHANNELS-1:0]  en_r;
    logic [CHANNELS-1:0]  en_nxt_s;
    logic [CHANNELS-1:0]  wr_sel_s;

    // Two-flop synchroniser for the asynchronous PLL lock input
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_meta_r <= 1'b0;
            lock_s_r    <= 1'b0;
        end else begin
            lock_meta_r <= pll_locked;
            lock_s_r    <= lock_meta_r;
        end
    end

    // Whether the state register will be RUN after the coming edge.
    // The hold counter counts observed lock cycles starting at 1, so RUN is
    // entered after exactly HOLD_CYCLES consecutive cycles of lock_s.
    always_comb begin
        go_run_s = 1'b0;
        case (state_r)
            ST_WAIT_LOCK: go_run_s = lock_s_r && SINGLE_HOLD;
            ST_HOLD:      go_run_s = lock_s_r && (hold_cnt_r == HOLD_LAST);
            ST_RUN:       go_run_s = lock_s_r;
            default:      go_run_s = 1'b0;
        endcase
    end

    // Lock-qualification FSM with outputs registered from the next state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r        <= ST_WAIT_LOCK;
            hold_cnt_r     <= HOLD_ZERO;
            ready_r        <= 1'b0;
            sys_resetn_r   <= 1'b0;
            lock_dropped_r <= 1'b0;
        end else begin
            ready_r      <= go_run_s;
            sys_resetn_r <= go_run_s;
            case (state_r)
                ST_WAIT_LOCK: begin
                    hold_cnt_r <= (lock_s_r && !go_run_s) ? HOLD_ONE : HOLD_ZERO;
                    if (go_run_s) begin
                        state_r <= ST_RUN;
                    end else if (lock_s_r) begin
                        state_r <= ST_HOLD;
                    end else begin
                        state_r <= ST_WAIT_LOCK;
                    end
                end
                ST_HOLD: begin
                    if (!lock_s_r) begin
                        state_r    <= ST_WAIT_LOCK;
                        hold_cnt_r <= HOLD_ZERO;
                    end else if (go_run_s) begin
                        state_r    <= ST_RUN;
                        hold_cnt_r <= HOLD_ZERO;
                    end else begin
                        hold_cnt_r <= hold_cnt_r + HOLD_ONE;
                    end
                end
                ST_RUN: begin
                    hold_cnt_r <= HOLD_ZERO;
                    if (!lock_s_r) begin
                        state_r        <= ST_WAIT_LOCK;
                        lock_dropped_r <= 1'b1;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    state_r    <= ST_WAIT_LOCK;
                    hold_cnt_r <= HOLD_ZERO;
                end
            endcase
        end
    end

    // Decode the divisor write; indices at or above CHANNELS match nothing
    always_comb begin
        wr_sel_s = {CHANNELS{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            wr_sel_s[i] = div_wr && (div_sel == SEL_W'(i));
        end
    end

    // Next channel state. In RUN the current strobe marks the wrap cycle:
    // the counter restarts and the shadow divisor becomes active, so a
    // period in progress always finishes with its old divisor. The strobe
    // is registered from the next counter/divisor pair.
    always_comb begin
        en_nxt_s = {CHANNELS{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            shd_nxt_s[i] = wr_sel_s[i] ? div_data : shd_r[i];
            if (state_r == ST_RUN) begin
                act_nxt_s[i] = en_r[i] ? shd_r[i] : act_r[i];
            end else begin
                act_nxt_s[i] = wr_sel_s[i] ? div_data : act_r[i];
            end
            cnt_nxt_s[i] = ((state_r == ST_RUN) && go_run_s && !en_r[i]) ?
                           (cnt_r[i] + ONE_C) : ZERO_C;
            en_nxt_s[i]  = go_run_s &&
                           ((act_nxt_s[i] <= ONE_C) ||
                            (cnt_nxt_s[i] == (act_nxt_s[i] - ONE_C)));
        end
    end

    // Channel counters, divisors and strobe registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_r[i] <= ZERO_C;
                act_r[i] <= DIV_INIT[i*CNT_WIDTH +: CNT_WIDTH];
                shd_r[i] <= DIV_INIT[i*CNT_WIDTH +: CNT_WIDTH];
            end
            en_r <= {CHANNELS{1'b0}};
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
                act_r[i] <= act_nxt_s[i];
                shd_r[i] <= shd_nxt_s[i];
            end
            en_r <= en_nxt_s;
        end
    end

    assign ready        = ready_r;
    assign sys_resetn   = sys_resetn_r;
    assign lock_dropped = lock_dropped_r;
    assign en           = en_r;

endmodule

// File: tb/tb_clock_enable_gen.sv
// Self-checking bench for clock_enable_gen: three channels with reset
// divisors {ch0=1, ch1=5, ch2=4}, HOLD_CYCLES=8. Expected outputs are
// queued with the stimulus and compared after the following clock edge.
module tb_clock_enable_gen;

    localparam int CH = 3;
    localparam int CW = 16;
    localparam int HC = 8;

    logic          clk = 1'b0;
    logic          resetn;
    logic          pll_locked;
    logic          div_wr;
    logic [1:0]    div_sel;
    logic [CW-1:0] div_data;
    logic          ready;
    logic          sys_resetn;
    logic          lock_dropped;
    logic [CH-1:0] en;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string         tag;
        logic          rdy;
        logic          srn;
        logic          drp;
        logic [CH-1:0] en;
    } exp_t;

    typedef struct {
        logic          lock;
        logic          wr;
        logic [1:0]    sel;
        logic [CW-1:0] data;
        logic          rdy;
        logic [CH-1:0] en;
    } vec_t;

    exp_t sb_q[$];
    vec_t tbl[26];

    clock_enable_gen #(
        .CHANNELS   (CH),
        .CNT_WIDTH  (CW),
        .HOLD_CYCLES(HC),
        .DIV_INIT   ({16'd4, 16'd5, 16'd1})
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .pll_locked  (pll_locked),
        .div_wr      (div_wr),
        .div_sel     (div_sel),
        .div_data    (div_data),
        .ready       (ready),
        .sys_resetn  (sys_resetn),
        .lock_dropped(lock_dropped),
        .en          (en)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before the end of the test");
        $fatal(1, "watchdog");
    end

    // Strobe pattern of fixed divisors, RUN cycle r (0-based)
    function automatic logic [CH-1:0] en_exp(int r, int d0, int d1, int d2);
        int d[CH];
        logic [CH-1:0] v;
        d = '{d0, d1, d2};
        v = '0;
        for (int i = 0; i < CH; i++) begin
            v[i] = (d[i] <= 1) ? 1'b1 : ((r % d[i]) == (d[i] - 1));
        end
        return v;
    endfunction

    function automatic void push(string tag, logic rdy, logic srn, logic drp, logic [CH-1:0] e);
        exp_t x;
        x.tag = tag; x.rdy = rdy; x.srn = srn; x.drp = drp; x.en = e;
        sb_q.push_back(x);
    endfunction

    task automatic cmp(string tag, string sig, logic [CH-1:0] act, logic [CH-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s: got %b, expected %b", tag, sig, act, req);
        end
    endtask

    task automatic drain();
        exp_t x;
        while (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            cmp(x.tag, "ready",        {2'b00, ready},        {2'b00, x.rdy});
            cmp(x.tag, "sys_resetn",   {2'b00, sys_resetn},   {2'b00, x.srn});
            cmp(x.tag, "lock_dropped", {2'b00, lock_dropped}, {2'b00, x.drp});
            cmp(x.tag, "en",           en,                    x.en);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        drain();
    endtask

    task automatic restart();
        resetn     = 1'b0;
        pll_locked = 1'b0;
        div_wr     = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    // Raise lock and expect RUN exactly 10 edges later
    task automatic go_run(string tag, logic drp, int d0, int d1, int d2);
        pll_locked = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            push(tag, k == 10, k == 10, drp, (k == 10) ? en_exp(0, d0, d1, d2) : 3'b000);
            tick();
        end
    endtask

    task automatic run_cycles(string tag, logic drp, int r_from, int r_to, int d0, int d1, int d2);
        for (int r = r_from; r <= r_to; r++) begin
            push(tag, 1'b1, 1'b1, drp, en_exp(r, d0, d1, d2));
            tick();
        end
    endtask

    initial begin
        resetn = 1'b0; pll_locked = 1'b0; div_wr = 1'b0; div_sel = 2'd0; div_data = 16'd0;

        // Table: lock sequence then divider pattern, rows are edges 1..26
        for (int j = 0; j < 26; j++) begin
            tbl[j].lock = 1'b1;
            tbl[j].wr   = 1'b0;
            tbl[j].sel  = 2'd0;
            tbl[j].data = 16'd0;
            tbl[j].rdy  = (j + 1) >= 10;
            tbl[j].en   = ((j + 1) >= 10) ? en_exp(j + 1 - 10, 1, 5, 4) : 3'b000;
        end

        #2;
        push("reset", 1'b0, 1'b0, 1'b0, 3'b000);
        drain();
        @(negedge clk);
        resetn = 1'b1;

        for (int j = 0; j < 26; j++) begin
            pll_locked = tbl[j].lock;
            div_wr     = tbl[j].wr;
            div_sel    = tbl[j].sel;
            div_data   = tbl[j].data;
            push("table", tbl[j].rdy, tbl[j].rdy, 1'b0, tbl[j].en);
            tick();
        end

        // Glitch-free update (ch2 4->2 written in cycle 1) and a write to
        // ch1 (5->3) in its wrap cycle 4, which must take one more period
        restart();
        go_run("relock", 1'b0, 1, 5, 4);
        for (int r = 1; r <= 15; r++) begin
            logic [CH-1:0] e;
            div_wr   = ((r - 1) == 1) || ((r - 1) == 4);
            div_sel  = ((r - 1) == 1) ? 2'd2 : 2'd1;
            div_data = ((r - 1) == 1) ? 16'd2 : 16'd3;
            e[0] = 1'b1;
            e[1] = (r == 4) || (r == 9) || (r == 12) || (r == 15);
            e[2] = (r >= 3) && (r % 2 == 1);
            push("update", 1'b1, 1'b1, 1'b0, e);
            tick();
        end
        div_wr = 1'b0;

        // Asynchronous reset mid-RUN, no clock edge involved
        #2;
        resetn     = 1'b0;
        pll_locked = 1'b0;
        #1;
        push("async_rst", 1'b0, 1'b0, 1'b0, 3'b000);
        drain();
        @(negedge clk);
        resetn = 1'b1;

        // Out-of-range write ignored; ch0 write outside RUN applies at once
        div_wr = 1'b1; div_sel = 2'd3; div_data = 16'd7;
        push("wr_idle", 1'b0, 1'b0, 1'b0, 3'b000);
        tick();
        div_sel = 2'd0; div_data = 16'd3;
        push("wr_idle", 1'b0, 1'b0, 1'b0, 3'b000);
        tick();
        div_wr = 1'b0;
        go_run("range", 1'b0, 3, 5, 4);
        run_cycles("range", 1'b0, 1, 14, 3, 5, 4);

        // Lock loss in RUN: all low within 3 edges, sticky flag, relock
        pll_locked = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        push("loss", 1'b0, 1'b0, 1'b1, 3'b000);
        tick();
        go_run("relock_drop", 1'b1, 3, 5, 4);
        run_cycles("relock_drop", 1'b1, 1, 5, 3, 5, 4);

        // Lock bounce during HOLD restarts the full hold interval
        restart();
        pll_locked = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            push("bounce", 1'b0, 1'b0, 1'b0, 3'b000);
            tick();
        end
        pll_locked = 1'b0;
        push("bounce", 1'b0, 1'b0, 1'b0, 3'b000);
        tick();
        go_run("bounce", 1'b0, 1, 5, 4);
        run_cycles("bounce", 1'b0, 1, 4, 1, 5, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
